led_counter_sprite: RTL and testbench
=====================================

// Module: led_counter_sprite
// PURPOSE
//  Upstream driver and pixel compositor for the 32x32 RGB565 LED sprite ROMs (rom_led_on / rom_led_off).
//  Keeps an N-bit binary counter that advances on frame ticks and renders it as a row of LED sprites.
//  Turns VGA pixel coordinates into ROM addresses; the on/off ROM output for each bit is selected by that bit.
//  Output is a latency-aligned RGB565 pixel plus a hit flag, consumed by the VGA output mux.
// PARAMETERS
//  N_LEDS      8     number of LEDs/counter bits; MSB drawn leftmost
//  X0          64    x of left edge of LED 0 (MSB)
//  Y0          200   y of top edge of all LEDs
//  PITCH       40    x distance between LED left edges; must be >= 32
//  DIV         30    frame ticks per counter increment (>=1)
//  BG_COLOR    16'h0000  pixel_out value when hit=0
// PORTS
//  clk          in   1   pixel clock
//  reset        in   1   synchronous, active-high reset
//  x            in   10  current pixel column
//  y            in   10  current pixel row
//  de           in   1   x/y valid (visible area)
//  frame_tick   in   1   one-cycle pulse at start of vertical blank
//  run          in   1   1 = counter advances; 0 = counter holds
//  rom_ad       out  10  address to both ROMs, {row[4:0],col[4:0]}
//  rom_ce       out  1   clock enable to both ROMs
//  rom_oce      out  1   tied 1
//  rom_on_dout  in   16  rom_led_on data, valid 1 clk after rom_ad/rom_ce sampled
//  rom_off_dout in   16  rom_led_off data, same timing
//  count        out  N_LEDS  current counter value
//  pixel_out    out  16  RGB565 pixel
//  pixel_valid  out  1   de delayed by LATENCY
//  hit          out  1   pixel_out is sprite content
// BEHAVIOUR
//  Reset: count=0, divider=0, shown=0, rom_ad=0, rom_ce=0, pixel_out=BG_COLOR, pixel_valid=0, hit=0; all pipeline valids cleared.
//  Counter: on frame_tick with run=1, divider increments; when it reaches DIV-1 it returns to 0 and count+1 (mod 2^N_LEDS).
//   Counter wraps all-ones->0. run=0 freezes both divider and count.
//  Tear-free display: shown <= count (post-update value) on each frame_tick. Rendering uses only shown.
//  Stage 1 (edge after x/y): inbox = de & y in [Y0,Y0+31] & some i with x in [X0+i*PITCH, X0+i*PITCH+31], i<N_LEDS.
//   rom_ad <= {y-Y0, x-X0-i*PITCH}[4:0 each]; rom_ce <= inbox; sel1 <= shown[N_LEDS-1-i].
//   Outside box: rom_ad holds its value.
//  Stage 2: ROM registers data. Bypass mode, 1 clk. inbox/sel/de are delayed alongside.
//  Stage 3: px = sel ? rom_on_dout : rom_off_dout; hit <= inbox3 & (px != 0 or transparency disabled).
//   pixel_out <= hit ? px : BG_COLOR.
//  Total LATENCY = 3 clk from x/y/de to pixel_out/hit/pixel_valid. No stall; one pixel per clk.
//  Gaps between LEDs (PITCH>32) and pixels with de=0 give hit=0 and pixel_out=BG_COLOR.
//  frame_tick with de=1: the same-cycle pixel still uses the old shown. The new shown applies from the next cycle.
//  Column division: no divider. i is found by comparing against N_LEDS constant window bounds (parallel comparators).
// CONFIGURATION
//  LED_SPRITE_TRANSPARENCY_EN defined: ROM value 16'h0000 is transparent (hit=0, pixel_out=BG_COLOR).
//  Not defined: every in-box pixel gives hit=1, including black pixels.
// STRUCTURE
//  Shared include led_counter_defs.vh: SPRITE_W=32, SPRITE_H=32, ROM_AW=10, RGB_W=16, LATENCY=3.
//  Sub-module led_tick_counter: frame_tick divider + N-bit counter + shown snapshot (clk, reset, frame_tick, run -> count, shown).
//  The top level holds address generation, the delay pipeline and the output mux.
// TESTING
//  1 Reset mid-frame with de=1 inside LED 0 -> next 3 clk: hit=0, pixel_valid=0, pixel_out=0000, count=0.
//  2 x=64,y=200,de=1, shown=8'h80 -> rom_ad=10'h000 after 1 clk.
//    After 3 clk pixel_out = rom_on_dout[0] and hit=1. Same with shown=0 -> rom_off data.
//  3 x=95,y=231 -> rom_ad=10'h3FF. x=96..103 (gap) -> hit=0 three clk later. x=104,y=200 -> LED 1, rom_ad=0.
//  4 DIV=2, run=1, 4 frame_ticks -> count 0,1,1,2 after each. Preload 8'hFF -> next increment gives 8'h00.
//  5 run=0 over 5 frame_ticks -> count and divider unchanged. frame_tick concurrent with de=1 -> shown changes only after that cycle.
//  6 In-box ROM data 0000: with LED_SPRITE_TRANSPARENCY_EN, hit=0. Without it, hit=1 and pixel_out=0000.

Source files
------------

// File: rtl/led_counter_sprite_pkg.sv
// Types and helpers shared by the LED counter sprite compositor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_counter_sprite_pkg;
`include "led_counter_defs.vh"

   // Per-pixel side information carried alongside the ROM read.
   typedef struct packed {
      logic de;     // pixel is in the visible area
      logic inbox;  // pixel falls inside some LED sprite box
      logic sel;    // 1 = use the "on" sprite, 0 = the "off" sprite
   } pipe_t;

   // Left edge of LED i as a 16-bit coordinate, wide enough to never wrap.
   function automatic logic [15:0] led_left(input int i, input int x0, input int pitch);
      return 16'(x0 + i * pitch);
   endfunction
endpackage

// File: rtl/led_counter_defs.vh
// Shared geometry/timing constants for the LED counter sprite block.
// Included inside led_counter_sprite_pkg; guarded against double inclusion.
// SPRITE_W/H: sprite size, ROM_AW: ROM address width, RGB_W: pixel width, LATENCY: x/y to pixel.
`ifndef LED_COUNTER_DEFS_VH
`define LED_COUNTER_DEFS_VH
localparam int SPRITE_W = 32;
localparam int SPRITE_H = 32;
localparam int ROM_AW   = 10;
localparam int RGB_W    = 16;
localparam int LATENCY  = 3;
`endif

// File: rtl/led_tick_counter.sv
// Frame-tick divider driving an N-bit binary counter, plus a tear-free snapshot for display.
// Latency: count/shown update on the clock edge that samples frame_tick.
// Backpressure: none; run=0 freezes divider and counter.
module led_tick_counter
   import led_counter_sprite_pkg::*;
#(
   parameter int N_LEDS = 8,
   parameter int DIV    = 30
)(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_frame_tick,
   input  logic              i_run,
   output logic [N_LEDS-1:0] o_count,
   output logic [N_LEDS-1:0] o_shown
);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   logic [DIV_W-1:0]  r_div;
   logic [DIV_W-1:0]  w_div_nxt;
   logic [N_LEDS-1:0] r_count;
   logic [N_LEDS-1:0] w_count_nxt;
   logic [N_LEDS-1:0] r_shown;

   // Next divider/counter value: only a frame tick with run=1 moves anything.
   always_comb begin
      w_div_nxt   = r_div;
      w_count_nxt = r_count;
      if (i_frame_tick && i_run) begin
         if (r_div == DIV_LAST) begin
            w_div_nxt   = '0;
            w_count_nxt = r_count + N_LEDS'(1);
         end else begin
            w_div_nxt = r_div + DIV_W'(1);
         end
      end
   end

   // State update; shown takes the post-update count so the display never lags a frame.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_div   <= '0;
         r_count <= '0;
         r_shown <= '0;
      end else begin
         r_div   <= w_div_nxt;
         r_count <= w_count_nxt;
         if (i_frame_tick) begin
            r_shown <= w_count_nxt;
         end
      end
   end

   assign o_count = r_count;
   assign o_shown = r_shown;
endmodule

// File: rtl/led_counter_sprite.sv
// Renders an N-bit frame counter as a row of 32x32 LED sprites read from external on/off ROMs.
// Latency: 3 clk from x/y/de to pixel_out/hit/pixel_valid, one pixel per clock.
// Backpressure: none (no stall). LED_SPRITE_TRANSPARENCY_EN makes ROM value 0000 transparent.
module led_counter_sprite
   import led_counter_sprite_pkg::*;
#(
   parameter int          N_LEDS   = 8,
   parameter int          X0       = 64,
   parameter int          Y0       = 200,
   parameter int          PITCH    = 40,
   parameter int          DIV      = 30,
   parameter logic [15:0] BG_COLOR = 16'h0000
)(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [9:0]        i_x,
   input  logic [9:0]        i_y,
   input  logic              i_de,
   input  logic              i_frame_tick,
   input  logic              i_run,
   output logic [ROM_AW-1:0] o_rom_ad,
   output logic              o_rom_ce,
   output logic              o_rom_oce,
   input  logic [RGB_W-1:0]  i_rom_on_dout,
   input  logic [RGB_W-1:0]  i_rom_off_dout,
   output logic [N_LEDS-1:0] o_count,
   output logic [RGB_W-1:0]  o_pixel_out,
   output logic              o_pixel_valid,
   output logic              o_hit
);
   localparam logic [15:0] Y_TOP = 16'(Y0);
   localparam logic [15:0] Y_BOT = 16'(Y0 + SPRITE_H - 1);

   logic [N_LEDS-1:0] w_shown;
   logic [15:0]       w_x16;
   logic [15:0]       w_y16;
   logic              w_in_row;
   logic              w_in_col;
   logic [4:0]        w_row;
   logic [4:0]        w_col;
   logic              w_sel;
   logic              w_inbox;
   logic [ROM_AW-1:0] r_rom_ad;
   logic              r_rom_ce;
   pipe_t             r_s1;
   pipe_t             r_s2;
   logic [RGB_W-1:0]  w_px;
   logic              w_opaque;
   logic              w_hit_nxt;
   logic [RGB_W-1:0]  r_pixel_out;
   logic              r_pixel_valid;
   logic              r_hit;

   led_tick_counter #(
      .N_LEDS (N_LEDS),
      .DIV    (DIV)
   ) u_tick (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_frame_tick (i_frame_tick),
      .i_run        (i_run),
      .o_count      (o_count),
      .o_shown      (w_shown)
   );

   assign w_x16    = {6'd0, i_x};
   assign w_y16    = {6'd0, i_y};
   assign w_in_row = (w_y16 >= Y_TOP) && (w_y16 <= Y_BOT);
   assign w_row    = 5'(w_y16 - Y_TOP);

   // Column decode: one window comparator per LED, no divider; windows never overlap.
   always_comb begin
      w_in_col = 1'b0;
      w_col    = '0;
      w_sel    = 1'b0;
      for (int i = 0; i < N_LEDS; i++) begin
         if ((w_x16 >= led_left(i, X0, PITCH)) &&
             (w_x16 <= led_left(i, X0, PITCH) + 16'(SPRITE_W - 1))) begin
            w_in_col = 1'b1;
            w_col    = 5'(w_x16 - led_left(i, X0, PITCH));
            w_sel    = w_shown[N_LEDS-1-i];
         end
      end
   end

   assign w_inbox = i_de && w_in_row && w_in_col;

   // Stage 1: ROM address/enable; address holds outside the boxes to avoid needless toggling.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rom_ad <= '0;
         r_rom_ce <= 1'b0;
         r_s1     <= '0;
      end else begin
         r_rom_ce <= w_inbox;
         if (w_inbox) begin
            r_rom_ad <= {w_row, w_col};
         end
         r_s1 <= '{de: i_de, inbox: w_inbox, sel: w_sel};
      end
   end

   // Stage 2: side info waits one clock while the ROM registers its data.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s2 <= '0;
      end else begin
         r_s2 <= r_s1;
      end
   end

   assign w_px = r_s2.sel ? i_rom_on_dout : i_rom_off_dout;

`ifdef LED_SPRITE_TRANSPARENCY_EN
   assign w_opaque = (w_px != '0);
`else
   assign w_opaque = 1'b1;
`endif

   assign w_hit_nxt = r_s2.inbox && w_opaque;

   // Stage 3: output mux; anything that is not sprite content shows the background.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pixel_out   <= BG_COLOR;
         r_pixel_valid <= 1'b0;
         r_hit         <= 1'b0;
      end else begin
         r_pixel_out   <= w_hit_nxt ? w_px : BG_COLOR;
         r_pixel_valid <= r_s2.de;
         r_hit         <= w_hit_nxt;
      end
   end

   assign o_rom_ad      = r_rom_ad;
   assign o_rom_ce      = r_rom_ce;
   assign o_rom_oce     = 1'b1;
   assign o_pixel_out   = r_pixel_out;
   assign o_pixel_valid = r_pixel_valid;
   assign o_hit         = r_hit;
endmodule

// File: tb/tb_led_counter_sprite.sv
// Directed bench for led_counter_sprite with a small behavioural on/off ROM pair.
// Latency: checks pixel results 3 clk after the driven coordinate.
// Backpressure: n/a; DUT built with DIV=2 so counter steps are quick.
module tb_led_counter_sprite;
   logic        clk;
   logic        reset;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        de;
   logic        frame_tick;
   logic        run;
   logic [9:0]  rom_ad;
   logic        rom_ce;
   logic        rom_oce;
   logic [15:0] rom_on_dout;
   logic [15:0] rom_off_dout;
   logic [7:0]  count;
   logic [15:0] pixel_out;
   logic        pixel_valid;
   logic        hit;
   logic        zero_mode;

   int n_chk  = 0;
   int n_pass = 0;

   logic [9:0] ad_seen;
   logic       ce_seen;
   logic       exp_tr_hit;

   led_counter_sprite #(
      .N_LEDS   (8),
      .X0       (64),
      .Y0       (200),
      .PITCH    (40),
      .DIV      (2),
      .BG_COLOR (16'h0000)
   ) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_x            (x),
      .i_y            (y),
      .i_de           (de),
      .i_frame_tick   (frame_tick),
      .i_run          (run),
      .o_rom_ad       (rom_ad),
      .o_rom_ce       (rom_ce),
      .o_rom_oce      (rom_oce),
      .i_rom_on_dout  (rom_on_dout),
      .i_rom_off_dout (rom_off_dout),
      .o_count        (count),
      .o_pixel_out    (pixel_out),
      .o_pixel_valid  (pixel_valid),
      .o_hit          (hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM model: on = 111100_addr, off = 000011_addr; zero_mode returns black.
   always @(posedge clk) begin
      if (rom_ce) begin
         rom_on_dout  <= zero_mode ? 16'h0000 : {6'b111100, rom_ad};
         rom_off_dout <= zero_mode ? 16'h0000 : {6'b000011, rom_ad};
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one pixel for one clock, capture stage-1 ROM address, return when its result is out.
   task automatic pix(input logic [9:0] px, input logic [9:0] py, input logic pde);
      x = px; y = py; de = pde;
      step();
      ad_seen = rom_ad;
      ce_seen = rom_ce;
      x = 10'd0; y = 10'd0; de = 1'b0;
      step();
      step();
   endtask

   task automatic ftick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   initial begin
      reset = 1'b1; x = 10'd64; y = 10'd200; de = 1'b1;
      frame_tick = 1'b0; run = 1'b1; zero_mode = 1'b0;
      rom_on_dout = 16'h0; rom_off_dout = 16'h0;

      // Reset state while a visible in-box pixel is presented
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("rst_hit", 32'(hit), 32'd0);
         check_eq("rst_valid", 32'(pixel_valid), 32'd0);
         check_eq("rst_pixel", 32'(pixel_out), 32'h0000);
         check_eq("rst_count", 32'(count), 32'd0);
      end
      check_eq("rst_rom_ad", 32'(rom_ad), 32'd0);
      check_eq("rst_rom_ce", 32'(rom_ce), 32'd0);
      check_eq("rom_oce", 32'(rom_oce), 32'd1);
      reset = 1'b0; de = 1'b0;
      step();

      // LED 0 top-left, shown=0 -> off sprite
      pix(10'd64, 10'd200, 1'b1);
      check_eq("led0_ad", 32'(ad_seen), 32'h000);
      check_eq("led0_ce", 32'(ce_seen), 32'd1);
      check_eq("led0_pix", 32'(pixel_out), 32'h0C00);
      check_eq("led0_hit", 32'(hit), 32'd1);
      check_eq("led0_valid", 32'(pixel_valid), 32'd1);

      // LED 0 bottom-right corner
      pix(10'd95, 10'd231, 1'b1);
      check_eq("corner_ad", 32'(ad_seen), 32'h3FF);
      check_eq("corner_pix", 32'(pixel_out), 32'h0FFF);

      // Gap between LED 0 and LED 1: address holds, no hit
      pix(10'd96, 10'd210, 1'b1);
      check_eq("gap96_ad_hold", 32'(ad_seen), 32'h3FF);
      check_eq("gap96_ce", 32'(ce_seen), 32'd0);
      check_eq("gap96_hit", 32'(hit), 32'd0);
      check_eq("gap96_pix", 32'(pixel_out), 32'h0000);
      check_eq("gap96_valid", 32'(pixel_valid), 32'd1);
      pix(10'd103, 10'd210, 1'b1);
      check_eq("gap103_hit", 32'(hit), 32'd0);

      // LED 1 left edge
      pix(10'd104, 10'd200, 1'b1);
      check_eq("led1_ad", 32'(ad_seen), 32'h000);
      check_eq("led1_hit", 32'(hit), 32'd1);
      check_eq("led1_pix", 32'(pixel_out), 32'h0C00);

      // Box boundaries
      pix(10'd63, 10'd200, 1'b1);
      check_eq("x63_hit", 32'(hit), 32'd0);
      pix(10'd70, 10'd199, 1'b1);
      check_eq("y199_hit", 32'(hit), 32'd0);
      pix(10'd70, 10'd232, 1'b1);
      check_eq("y232_hit", 32'(hit), 32'd0);
      pix(10'd375, 10'd215, 1'b1);
      check_eq("led7_ad", 32'(ad_seen), 32'h1FF);
      check_eq("led7_pix", 32'(pixel_out), 32'h0DFF);
      pix(10'd376, 10'd215, 1'b1);
      check_eq("x376_hit", 32'(hit), 32'd0);

      // de=0 inside a box
      pix(10'd70, 10'd205, 1'b0);
      check_eq("de0_hit", 32'(hit), 32'd0);
      check_eq("de0_valid", 32'(pixel_valid), 32'd0);
      check_eq("de0_pix", 32'(pixel_out), 32'h0000);

      // Divider DIV=2: counts 0,1,1,2
      ftick(); check_eq("tick1", 32'(count), 32'd0);
      ftick(); check_eq("tick2", 32'(count), 32'd1);
      ftick(); check_eq("tick3", 32'(count), 32'd1);
      ftick(); check_eq("tick4", 32'(count), 32'd2);
      ftick(); check_eq("tick5", 32'(count), 32'd2);

      // run=0 freezes divider (left at 1) and count
      run = 1'b0;
      for (int i = 0; i < 5; i++) ftick();
      check_eq("frozen_count", 32'(count), 32'd2);
      run = 1'b1;
      ftick(); check_eq("resume_count", 32'(count), 32'd3);
      ftick(); check_eq("tick7", 32'(count), 32'd3);

      // frame_tick concurrent with de=1 on LED 5 (bit 2): 3 -> 4
      x = 10'd264; y = 10'd200; de = 1'b1; frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      x = 10'd0; y = 10'd0; de = 1'b0;
      step();
      check_eq("tick_same_cycle_old", 32'(pixel_out), 32'h0C00);
      step();
      check_eq("tick_next_cycle_new", 32'(pixel_out), 32'hF000);
      check_eq("count4", 32'(count), 32'd4);

      // Advance to all-ones (251 increments) and render MSB on
      frame_tick = 1'b1;
      for (int i = 0; i < 502; i++) step();
      frame_tick = 1'b0;
      check_eq("count_ff", 32'(count), 32'hFF);
      pix(10'd64, 10'd200, 1'b1);
      check_eq("msb_on_pix", 32'(pixel_out), 32'hF000);
      check_eq("msb_on_hit", 32'(hit), 32'd1);
      ftick(); ftick();
      check_eq("wrap_count", 32'(count), 32'h00);
      pix(10'd64, 10'd200, 1'b1);
      check_eq("wrap_off_pix", 32'(pixel_out), 32'h0C00);

      // Black ROM data inside a box
      zero_mode = 1'b1;
`ifdef LED_SPRITE_TRANSPARENCY_EN
      exp_tr_hit = 1'b0;
`else
      exp_tr_hit = 1'b1;
`endif
      pix(10'd70, 10'd205, 1'b1);
      check_eq("black_ad", 32'(ad_seen), 32'h0A6);
      check_eq("black_hit", 32'(hit), 32'(exp_tr_hit));
      check_eq("black_pix", 32'(pixel_out), 32'h0000);
      check_eq("black_valid", 32'(pixel_valid), 32'd1);
      zero_mode = 1'b0;

      // Reset mid-frame with in-box pixels in flight and count nonzero
      ftick(); ftick();
      check_eq("pre_reset_count", 32'(count), 32'd1);
      x = 10'd64; y = 10'd200; de = 1'b1;
      step(); step();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("mid_rst_hit", 32'(hit), 32'd0);
         check_eq("mid_rst_valid", 32'(pixel_valid), 32'd0);
         check_eq("mid_rst_pix", 32'(pixel_out), 32'h0000);
         check_eq("mid_rst_count", 32'(count), 32'd0);
      end
      reset = 1'b0; de = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
